// File: rtl/rr_arbiter8_pkg.sv
// Shared constants, FSM encoding and helpers for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;
  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter8_if;
  import rr_arbiter8_pkg::*;

  // 'release' is a reserved word in SystemVerilog, hence 'rel'.
  logic [NUM_REQ-1:0] req;
  logic               rel;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               timeout;

  modport master (output req, rel, input grant, grant_idx, grant_valid, timeout);
  modport slave  (input req, rel, output grant, grant_idx, grant_valid, timeout);
endinterface

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping 7->0.
module rr_pick8
  import rr_arbiter8_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any_req
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     offset;

  // Rotate so ptr lands on bit 0, then take the lowest set bit and undo the rotation.
  always_comb begin
    dbl    = {req, req} >> ptr;
    rot    = dbl[NUM_REQ-1:0];
    offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) offset = IDX_W'(k);
    end
    pick_idx = ptr + offset;
    any_req  = |req;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant and hold budget.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter8_if.slave  bus
);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   hold_cnt;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   idx_q;
  logic               valid_q;

  logic [IDX_W-1:0]   pick_idx;
  logic               any_req;
  logic               at_limit;
  logic               owner_req;
  logic               end_grant;

  rr_pick8 u_pick (
    .req      (bus.req),
    .ptr      (ptr),
    .pick_idx (pick_idx),
    .any_req  (any_req)
  );

  assign at_limit  = (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign owner_req = bus.req[idx_q];
  assign end_grant = bus.rel | ~owner_req | at_limit;

  // Timeout only flags the cycle the budget actually ends the grant; release or a
  // dropped request in that same cycle take precedence.
  assign bus.timeout     = (state == GRANT) & ~bus.rel & owner_req & at_limit;
  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant_q  <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_q  <= onehot(pick_idx);
            idx_q    <= pick_idx;
            valid_q  <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (end_grant) begin
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr     <= idx_q + IDX_W'(1);
            state   <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scenario bench for rr_arbiter8 with a grant-record scoreboard (MAX_HOLD=4).
module tb_rr_arbiter8;
  import rr_arbiter8_pkg::*;

  typedef struct {
    int idx;
    int len;
    int to_cnt;
    int to_last;
    int gap;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rec_t exp_q[$];
  rec_t obs_q[$];
  rec_t cur;
  bit   active = 1'b0;
  int   idle_cnt = 0;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Monitor: checks grant/index/timeout consistency each cycle and logs each grant.
  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      active   = 1'b0;
      idle_cnt = 0;
    end else begin
      checks++;
      if (bus.grant_valid ? (bus.grant !== (8'h01 << bus.grant_idx))
                          : (bus.grant !== 8'h00 || bus.grant_idx !== 3'd0 || bus.timeout !== 1'b0)) begin
        errors++;
        $display("FAIL consistency: grant=%h grant_idx=%0d grant_valid=%b timeout=%b",
                 bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout);
      end
      if (bus.grant_valid === 1'b1) begin
        if (!active) begin
          active     = 1'b1;
          cur.idx    = int'(bus.grant_idx);
          cur.len    = 0;
          cur.to_cnt = 0;
          cur.gap    = idle_cnt;
        end
        cur.len++;
        cur.to_cnt += int'(bus.timeout);
        cur.to_last = int'(bus.timeout);
        idle_cnt    = 0;
      end else begin
        if (active) begin
          obs_q.push_back(cur);
          active = 1'b0;
        end
        idle_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.grant_valid !== 1'b1 && n < 20);
    checks++;
    if (bus.grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: grant_valid=%b after %0d cycles, required 1", name, bus.grant_valid, n);
    end
  endtask

  task automatic pulse_rel();
    @(posedge clk); #1;
    bus.rel = 1'b1;
    @(posedge clk); #1;
    bus.rel = 1'b0;
  endtask

  function automatic rec_t mk(input int idx, input int len, input int to_cnt,
                              input int to_last, input int gap);
    rec_t r;
    r.idx = idx; r.len = len; r.to_cnt = to_cnt; r.to_last = to_last; r.gap = gap;
    return r;
  endfunction

  task automatic test_reset();
    bus.req = '0;
    bus.rel = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: grant=%h idx=%0d valid=%b timeout=%b, required all 0",
               bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout);
    end
    rst_n   = 1'b1;
    bus.req = 8'h04;
    wait_valid("reset_pre");
    checks++;
    if (bus.grant !== 8'h04) begin
      errors++;
      $display("FAIL reset_pre_grant: grant=%h, required 04", bus.grant);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout} !== 13'd0) begin
      errors++;
      $display("FAIL reset_async: grant=%h idx=%0d valid=%b timeout=%b, required all 0",
               bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout);
    end
    @(posedge clk); #1;
    rst_n   = 1'b1;
    bus.req = 8'h80;
    @(negedge clk);
    checks++;
    if (bus.grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_latency: grant_valid=%b before first edge, required 0", bus.grant_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.grant !== 8'h80 || bus.grant_idx !== 3'd7) begin
      errors++;
      $display("FAIL reset_first: grant=%h idx=%0d, required 80 idx 7", bus.grant, bus.grant_idx);
    end
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_round_robin();
    rec_t e, o;
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(mk(k % 8, 2, 0, 0, (k == 0) ? -1 : 1));
      wait_valid("rr_wait");
      pulse_rel();
    end
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL rr_seq: no grant observed, required idx %0d", e.idx);
      end else begin
        o = obs_q.pop_front();
        if (o.idx !== e.idx || o.len !== e.len || o.to_cnt !== e.to_cnt || o.to_last !== e.to_last ||
            (e.gap >= 0 && o.gap !== e.gap)) begin
          errors++;
          $display("FAIL rr_seq: got idx=%0d len=%0d to=%0d/%0d gap=%0d, required idx=%0d len=%0d to=%0d/%0d gap=%0d",
                   o.idx, o.len, o.to_cnt, o.to_last, o.gap, e.idx, e.len, e.to_cnt, e.to_last, e.gap);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL rr_extra: %0d unexpected grants, required 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_wrap_skip();
    rec_t e, o;
    bus.req = 8'h40;
    exp_q.push_back(mk(6, 2, 0, 0, -1));
    wait_valid("wrap_first");
    pulse_rel();
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;
    bus.req = 8'h09;
    exp_q.push_back(mk(0, 2, 0, 0, -1));
    wait_valid("wrap_zero");
    pulse_rel();
    exp_q.push_back(mk(3, 2, 0, 0, 1));
    wait_valid("wrap_three");
    pulse_rel();
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL wrap_seq: no grant observed, required idx %0d", e.idx);
      end else begin
        o = obs_q.pop_front();
        if (o.idx !== e.idx || o.len !== e.len || o.to_cnt !== e.to_cnt || o.to_last !== e.to_last ||
            (e.gap >= 0 && o.gap !== e.gap)) begin
          errors++;
          $display("FAIL wrap_seq: got idx=%0d len=%0d to=%0d/%0d gap=%0d, required idx=%0d len=%0d to=%0d/%0d gap=%0d",
                   o.idx, o.len, o.to_cnt, o.to_last, o.gap, e.idx, e.len, e.to_cnt, e.to_last, e.gap);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_extra: %0d unexpected grants, required 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_timeout();
    rec_t e, o;
    bus.req = 8'h02;
    exp_q.push_back(mk(1, 4, 1, 1, -1));
    exp_q.push_back(mk(1, 4, 1, 1, 1));
    wait_valid("timeout_wait");
    // Two full budgets plus the bubble; drop req right after the second expiry edge.
    repeat (9) @(posedge clk);
    #1;
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL timeout_seq: no grant observed, required idx %0d", e.idx);
      end else begin
        o = obs_q.pop_front();
        if (o.idx !== e.idx || o.len !== e.len || o.to_cnt !== e.to_cnt || o.to_last !== e.to_last ||
            (e.gap >= 0 && o.gap !== e.gap)) begin
          errors++;
          $display("FAIL timeout_seq: got idx=%0d len=%0d to=%0d/%0d gap=%0d, required idx=%0d len=%0d to=%0d/%0d gap=%0d",
                   o.idx, o.len, o.to_cnt, o.to_last, o.gap, e.idx, e.len, e.to_cnt, e.to_last, e.gap);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_extra: %0d unexpected grants, required 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_collision();
    rec_t e, o;
    bus.req = 8'h02;
    exp_q.push_back(mk(1, 4, 0, 0, -1));
    wait_valid("collide_wait");
    repeat (3) @(posedge clk);
    #1;
    bus.rel = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.timeout !== 1'b0 || bus.grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL collide_pulse: timeout=%b valid=%b, required timeout 0 valid 1",
               bus.timeout, bus.grant_valid);
    end
    @(posedge clk); #1;
    bus.rel = 1'b0;
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL collide_seq: no grant observed, required idx %0d", e.idx);
      end else begin
        o = obs_q.pop_front();
        if (o.idx !== e.idx || o.len !== e.len || o.to_cnt !== e.to_cnt || o.to_last !== e.to_last) begin
          errors++;
          $display("FAIL collide_seq: got idx=%0d len=%0d to=%0d/%0d, required idx=%0d len=%0d to=%0d/%0d",
                   o.idx, o.len, o.to_cnt, o.to_last, e.idx, e.len, e.to_cnt, e.to_last);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL collide_extra: %0d unexpected grants, required 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_req_drop();
    rec_t e, o;
    bus.req = 8'h20;
    exp_q.push_back(mk(5, 2, 0, 0, -1));
    wait_valid("drop_wait");
    @(posedge clk); #1;
    bus.req = 8'h04;
    exp_q.push_back(mk(2, 2, 0, 0, 1));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_clear: grant_valid=%b, required 0", bus.grant_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd2) begin
      errors++;
      $display("FAIL drop_next: valid=%b idx=%0d, required valid 1 idx 2", bus.grant_valid, bus.grant_idx);
    end
    pulse_rel();
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;
    bus.rel = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.grant !== 8'h00) begin
      errors++;
      $display("FAIL idle_release: grant=%h valid=%b, required 00 valid 0", bus.grant, bus.grant_valid);
    end
    @(posedge clk); #1;
    bus.rel = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.grant !== 8'h00) begin
      errors++;
      $display("FAIL idle_release_after: grant=%h valid=%b, required 00 valid 0", bus.grant, bus.grant_valid);
    end
    @(posedge clk); #1;
    // Pointer must still sit just past idx 2.
    bus.req = 8'hFF;
    exp_q.push_back(mk(3, 2, 0, 0, -1));
    wait_valid("drop_ptr");
    @(posedge clk); #1;
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL drop_seq: no grant observed, required idx %0d", e.idx);
      end else begin
        o = obs_q.pop_front();
        if (o.idx !== e.idx || o.len !== e.len || o.to_cnt !== e.to_cnt || o.to_last !== e.to_last ||
            (e.gap >= 0 && o.gap !== e.gap)) begin
          errors++;
          $display("FAIL drop_seq: got idx=%0d len=%0d to=%0d/%0d gap=%0d, required idx=%0d len=%0d to=%0d/%0d gap=%0d",
                   o.idx, o.len, o.to_cnt, o.to_last, o.gap, e.idx, e.len, e.to_cnt, e.to_last, e.gap);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL drop_extra: %0d unexpected grants, required 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap_skip();
    test_timeout();
    test_collision();
    test_req_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one downstream resource (e.g. a bus or encoder datapath) between 8 requesters.
- Issues a registered one-hot grant plus its 3-bit binary index.
- Holds the grant until the owner releases it, drops its request, or exceeds a hold budget.
- Sits between 8 request sources and the shared resource's select/enable inputs.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one requester may hold a grant (legal range 2..256).
- CNT_W, 8, hold-counter width; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i = requester i.
- release  input  1  current owner finished; valid only while grant_valid=1.
- grant  output  8  registered one-hot grant; all-zero when idle.
- grant_idx  output  3  binary index of the set grant bit; 0 when idle.
- grant_valid  output  1  high while any grant bit is set.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold budget.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n. Reset values: grant=0, grant_idx=0, grant_valid=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If req != 0, pick the first set bit searching upward from ptr and wrapping 7->0.
  - Next edge: grant=onehot(pick), grant_idx=pick, grant_valid=1, hold_cnt=0, state=GRANT.
  - Latency from req sampled to grant visible is 1 cycle.
  - If req == 0, stay in IDLE with outputs 0.
- GRANT: each cycle evaluate end conditions in priority order (let i = grant_idx):
  - (1) release=1 -> end, timeout=0.
  - (2) req[i]=0 -> end, timeout=0.
  - (3) hold_cnt == MAX_HOLD-1 -> end, timeout=1 for that cycle only.
  - Otherwise hold_cnt++ and the grant is unchanged.
- End of grant (next edge): grant=0, grant_idx=0, grant_valid=0, ptr=(i+1) mod 8 with 3-bit wrap, state=IDLE.
  - A 1-cycle idle bubble is mandatory between consecutive grants, so the earliest next grant is 2 edges after the end condition.
- Grant duration: the owner holds at most MAX_HOLD cycles. grant_valid stays high for exactly MAX_HOLD cycles on timeout.
- Boundary conditions:
  - release while in IDLE is ignored.
  - release and timeout in the same cycle: release wins, no timeout pulse.
  - A new req bit rising during GRANT does not pre-empt; it is considered at the next IDLE.
  - All 8 requesting continuously: grants cycle 0,1,...,7,0 with no starvation.
  - ptr=7 with req=8'h01: grant goes to 0 (wrap).
  - grant is always one-hot or zero. grant_idx always equals encode(grant).
  - Reset mid-grant: outputs clear immediately (asynchronously). After deassertion the first grant uses ptr=0.
- Reset release is synchronised upstream; deassertion is treated as synchronous to clk.

Decomposition:
- Shared package/header constants: NUM_REQ=8, IDX_W=3, state encodings IDLE=1'b0, GRANT=1'b1.
- One combinational sub-module, rr_pick8, is natural:
  - Inputs req[7:0], ptr[2:0].
  - Outputs pick_idx[2:0] and any_req.
  - Implemented as rotate-right by ptr, fixed-priority LSB-first search, add ptr mod 8.
- FSM, hold counter and output registers live in rr_arbiter8.

Test Plan:
- Reset: assert rst_n=0 mid-grant with grant=8'h04 -> grant, grant_idx, grant_valid and timeout go to 0 without waiting for a clk edge. After release, req=8'h80 -> grant=8'h80, grant_idx=7 one cycle later.
- Round-robin fairness: req=8'hFF held, release pulsed 1 cycle after each grant -> grant_idx sequence 0,1,2,...,7,0. Each grant is separated by a 1-cycle idle gap.
- Wrap and skip: first a single grant to idx 6 ends, so ptr=7. Then req=8'h09 -> grant_idx=0 next. After its release -> grant_idx=3.
- Timeout: MAX_HOLD=4, req=8'h02 held, no release -> grant_valid high exactly 4 cycles. timeout=1 on the 4th cycle only. The next grant is idx 1 again after a 1-cycle gap.
- Release/timeout collision: MAX_HOLD=4, release=1 on the 4th grant cycle -> grant drops, timeout stays 0.
- Request drop and ignored release: owner idx 5 drops req[5] on the 2nd grant cycle with req[2]=1 -> grant clears next edge, then grant_idx=2 one cycle later. release pulsed while idle -> no output change.
